// File: rtl/fb_pkg.sv
// Shared widths, defaults and the per-requester access bundle for the
// frame-buffer port arbiter.
package fb_pkg;

  localparam int FB_COLS_DEF = 336;
  localparam int FB_ROWS_DEF = 256;
  localparam int FB_COL_W    = 9;
  localparam int FB_ROW_W    = 8;
  localparam int FB_DATA_W   = 8;

  typedef struct packed {
    logic                 we;
    logic [FB_COL_W-1:0]  col;
    logic [FB_ROW_W-1:0]  row;
    logic [FB_DATA_W-1:0] wdata;
  } fb_acc_t;

  function automatic logic fb_in_range(input logic [FB_COL_W-1:0] col,
                                       input logic [FB_ROW_W-1:0] row,
                                       input int                  cols,
                                       input int                  rows);
    return (int'(col) < cols) && (int'(row) < rows);
  endfunction

endpackage

// File: rtl/fb_rr_pick.sv
// Combinational requester picker: round-robin from ptr when rr=1,
// otherwise fixed priority with requester 0 highest.
module fb_rr_pick
  import fb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             rr,
  output logic [NREQ-1:0]  win,
  output logic             win_vld
);

  logic [PTR_W-1:0] idx;

  // Scan candidates in priority order and keep the first requesting one.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr ? PTR_W'((int'(ptr) + k) % NREQ) : PTR_W'(k);
      if (!win_vld && req[idx]) begin
        win[idx] = 1'b1;
        win_vld  = 1'b1;
      end else begin
        win_vld  = win_vld;
      end
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port A arbiter: one access per cycle, registered port drive,
// 2-edge read return. Optional bounds check under FB_ARB_BOUNDS_CHK_EN.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RR      = 1,
  parameter int FB_COLS = FB_COLS_DEF,
  parameter int FB_ROWS = FB_ROWS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*FB_COL_W-1:0]  req_col,
  input  logic [NREQ*FB_ROW_W-1:0]  req_row,
  input  logic [NREQ*FB_DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           rvalid,
  output logic [FB_DATA_W-1:0]      rdata,
  output logic                      fb_we,
  output logic [FB_COL_W-1:0]       fb_col,
  output logic [FB_ROW_W-1:0]       fb_row,
  output logic [FB_DATA_W-1:0]      fb_di,
`ifdef FB_ARB_BOUNDS_CHK_EN
  output logic                      oob_err,
`endif
  input  logic [FB_DATA_W-1:0]      fb_do
);

  localparam int PTR_W = (NREQ > 2) ? 2 : 1;

  fb_acc_t          acc [NREQ];
  fb_acc_t          sel;
  logic [NREQ-1:0]  win;
  logic             win_vld;
  logic [PTR_W-1:0] win_idx;
  logic             sel_oob;

  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [NREQ-1:0]      rpend_q, rpend_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 gnt_rd_q, gnt_rd_d;
  logic                 gnt_oob_q, gnt_oob_d;
  logic                 rpend_oob_q, rpend_oob_d;
  logic                 fb_we_q, fb_we_d;
  logic [FB_COL_W-1:0]  fb_col_q, fb_col_d;
  logic [FB_ROW_W-1:0]  fb_row_q, fb_row_d;
  logic [FB_DATA_W-1:0] fb_di_q, fb_di_d;
`ifdef FB_ARB_BOUNDS_CHK_EN
  logic                 oob_err_q, oob_err_d;
`endif

  // Unpack the flat request buses into one access bundle per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      acc[i].we    = req_we[i];
      acc[i].col   = req_col[FB_COL_W*i +: FB_COL_W];
      acc[i].row   = req_row[FB_ROW_W*i +: FB_ROW_W];
      acc[i].wdata = req_wdata[FB_DATA_W*i +: FB_DATA_W];
    end
  end

  fb_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .rr      (RR != 0),
    .win     (win),
    .win_vld (win_vld)
  );

  // Convert the one-hot winner into an index and select its bundle.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_idx = win[i] ? PTR_W'(i) : win_idx;
    end
    sel = acc[win_idx];
`ifdef FB_ARB_BOUNDS_CHK_EN
    sel_oob = !fb_in_range(sel.col, sel.row, FB_COLS, FB_ROWS);
`else
    sel_oob = 1'b0;
`endif
  end

  // Next-state: port drive, RR pointer and the read-return pipeline.
  always_comb begin
    gnt_d       = win;
    ptr_d       = ptr_q;
    fb_we_d     = 1'b0;
    fb_col_d    = fb_col_q;
    fb_row_d    = fb_row_q;
    fb_di_d     = fb_di_q;
    gnt_rd_d    = 1'b0;
    gnt_oob_d   = 1'b0;
    rpend_d     = gnt_rd_q ? gnt_q : '0;
    rpend_oob_d = gnt_rd_q & gnt_oob_q;
`ifdef FB_ARB_BOUNDS_CHK_EN
    oob_err_d   = oob_err_q;
`endif
    if (win_vld) begin
      fb_we_d   = sel.we & ~sel_oob;
      fb_col_d  = sel.col;
      fb_row_d  = sel.row;
      fb_di_d   = sel.wdata;
      gnt_rd_d  = ~sel.we;
      gnt_oob_d = sel_oob;
      ptr_d     = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + PTR_W'(1);
`ifdef FB_ARB_BOUNDS_CHK_EN
      oob_err_d = oob_err_q | sel_oob;
`endif
    end else begin
      ptr_d     = ptr_q;
    end
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      rpend_q     <= '0;
      ptr_q       <= '0;
      gnt_rd_q    <= 1'b0;
      gnt_oob_q   <= 1'b0;
      rpend_oob_q <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_col_q    <= '0;
      fb_row_q    <= '0;
      fb_di_q     <= '0;
`ifdef FB_ARB_BOUNDS_CHK_EN
      oob_err_q   <= 1'b0;
`endif
    end else begin
      gnt_q       <= gnt_d;
      rpend_q     <= rpend_d;
      ptr_q       <= ptr_d;
      gnt_rd_q    <= gnt_rd_d;
      gnt_oob_q   <= gnt_oob_d;
      rpend_oob_q <= rpend_oob_d;
      fb_we_q     <= fb_we_d;
      fb_col_q    <= fb_col_d;
      fb_row_q    <= fb_row_d;
      fb_di_q     <= fb_di_d;
`ifdef FB_ARB_BOUNDS_CHK_EN
      oob_err_q   <= oob_err_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rpend_q;
  assign fb_we  = fb_we_q;
  assign fb_col = fb_col_q;
  assign fb_row = fb_row_q;
  assign fb_di  = fb_di_q;
  // Out-of-range reads return zero instead of whatever the memory produced.
  assign rdata  = rpend_oob_q ? 8'h00 : fb_do;
`ifdef FB_ARB_BOUNDS_CHK_EN
  assign oob_err = oob_err_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: a round-robin instance on a frame-buffer
// model plus a fixed-priority instance sharing the same requests.
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [17:0] req_col;
  logic [15:0] req_row;
  logic [15:0] req_wdata;

  logic [1:0]  gnt, rvalid;
  logic [7:0]  rdata, fb_di, fb_do;
  logic        fb_we;
  logic [8:0]  fb_col;
  logic [7:0]  fb_row;

  logic [1:0]  fp_gnt, fp_rvalid;
  logic [7:0]  fp_rdata, fp_fb_di;
  logic        fp_fb_we;
  logic [8:0]  fp_fb_col;
  logic [7:0]  fp_fb_row;
  logic [7:0]  fp_fb_do;
`ifdef FB_ARB_BOUNDS_CHK_EN
  logic        oob_err, fp_oob_err;
`endif

  logic [7:0]  mem [0:86015];
  logic        pl_en;
  int          pl_addr;
  logic [7:0]  pl_data;

  int vec  = 0;
  int errs = 0;

  assign fp_fb_do = 8'h00;

  always #5 clk = ~clk;

  fb_port_arbiter #(.NREQ(2), .RR(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_col(req_col),
    .req_row(req_row), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .fb_we(fb_we), .fb_col(fb_col), .fb_row(fb_row), .fb_di(fb_di),
`ifdef FB_ARB_BOUNDS_CHK_EN
    .oob_err(oob_err),
`endif
    .fb_do(fb_do)
  );

  fb_port_arbiter #(.NREQ(2), .RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_col(req_col),
    .req_row(req_row), .req_wdata(req_wdata), .gnt(fp_gnt), .rvalid(fp_rvalid),
    .rdata(fp_rdata), .fb_we(fp_fb_we), .fb_col(fp_fb_col), .fb_row(fp_fb_row),
    .fb_di(fp_fb_di),
`ifdef FB_ARB_BOUNDS_CHK_EN
    .oob_err(fp_oob_err),
`endif
    .fb_do(fp_fb_do)
  );

  // 336x256 frame buffer with registered read; out-of-range reads return EE.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (fb_we && (fb_col < 9'd336)) mem[int'(fb_row) * 336 + int'(fb_col)] <= fb_di;
    fb_do <= (fb_col < 9'd336) ? mem[int'(fb_row) * 336 + int'(fb_col)] : 8'hEE;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [8:0] col,
                         input logic [7:0] row, input logic [7:0] wd);
    req_we[i]             = we;
    req_col[9*i +: 9]     = col;
    req_row[8*i +: 8]     = row;
    req_wdata[8*i +: 8]   = wd;
  endtask

  task automatic preload(input int col, input int row, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = row * 336 + col;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    preload(5, 3, 8'hA7);
    preload(10, 20, 8'h11);
    preload(335, 255, 8'h99);
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    vec++; if (rvalid !== 2'b00) begin errs++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
    vec++; if (fb_we !== 1'b0) begin errs++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
    vec++; if (fb_col !== 9'd0) begin errs++; $display("FAIL reset_fb_col: got %0d want 0", fb_col); end
    vec++; if (fb_row !== 8'd0) begin errs++; $display("FAIL reset_fb_row: got %0d want 0", fb_row); end
    vec++; if (fb_di !== 8'h00) begin errs++; $display("FAIL reset_fb_di: got %h want 00", fb_di); end
`ifdef FB_ARB_BOUNDS_CHK_EN
    vec++; if (oob_err !== 1'b0) begin errs++; $display("FAIL reset_oob_err: got %b want 0", oob_err); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single_read;
    set_req(0, 1'b0, 9'd5, 8'd3, 8'h00);
    req = 2'b01;
    tick();
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL sr_gnt: got %b want 01", gnt); end
    vec++; if (fb_we !== 1'b0) begin errs++; $display("FAIL sr_fb_we: got %b want 0", fb_we); end
    vec++; if (fb_col !== 9'd5 || fb_row !== 8'd3) begin errs++; $display("FAIL sr_addr: got %0d,%0d want 5,3", fb_col, fb_row); end
    vec++; if (rvalid !== 2'b00) begin errs++; $display("FAIL sr_rvalid_early: got %b want 00", rvalid); end
    req = 2'b00;
    tick();
    vec++; if (rvalid !== 2'b01) begin errs++; $display("FAIL sr_rvalid: got %b want 01", rvalid); end
    vec++; if (rdata !== 8'hA7) begin errs++; $display("FAIL sr_rdata: got %h want a7", rdata); end
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL sr_gnt_drop: got %b want 00", gnt); end
    tick();
    vec++; if (rvalid !== 2'b00) begin errs++; $display("FAIL sr_rvalid_end: got %b want 00", rvalid); end
  endtask

  task automatic test_write_read;
    set_req(0, 1'b1, 9'd335, 8'd255, 8'h3C);
    req = 2'b01;
    tick();
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL wr_gnt: got %b want 01", gnt); end
    vec++; if (fb_we !== 1'b1) begin errs++; $display("FAIL wr_fb_we: got %b want 1", fb_we); end
    vec++; if (fb_col !== 9'd335 || fb_row !== 8'd255) begin errs++; $display("FAIL wr_addr: got %0d,%0d want 335,255", fb_col, fb_row); end
    vec++; if (fb_di !== 8'h3C) begin errs++; $display("FAIL wr_fb_di: got %h want 3c", fb_di); end
    req = 2'b00;
    tick();
    vec++; if (fb_we !== 1'b0) begin errs++; $display("FAIL wr_fb_we_pulse: got %b want 0", fb_we); end
    vec++; if (rvalid !== 2'b00) begin errs++; $display("FAIL wr_no_rvalid: got %b want 00", rvalid); end
    set_req(1, 1'b0, 9'd335, 8'd255, 8'h00);
    req = 2'b10;
    tick();
    vec++; if (gnt !== 2'b10) begin errs++; $display("FAIL wr_rd_gnt: got %b want 10", gnt); end
    req = 2'b00;
    tick();
    vec++; if (rvalid !== 2'b10) begin errs++; $display("FAIL wr_rd_rvalid: got %b want 10", rvalid); end
    vec++; if (rdata !== 8'h3C) begin errs++; $display("FAIL wr_rd_rdata: got %h want 3c", rdata); end
    tick();
  endtask

  task automatic test_rr_contention;
    logic [1:0] exp_gnt [6];
    logic [1:0] exp_rv  [6];
    logic [7:0] exp_rd  [6];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    exp_rd  = '{8'h00, 8'hA7, 8'h3C, 8'hA7, 8'h3C, 8'hA7};
    set_req(0, 1'b0, 9'd5, 8'd3, 8'h00);
    set_req(1, 1'b0, 9'd335, 8'd255, 8'h00);
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick();
      vec++; if (gnt !== exp_gnt[k]) begin errs++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_gnt[k]); end
      vec++; if (rvalid !== exp_rv[k]) begin errs++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, rvalid, exp_rv[k]); end
      vec++; if (fp_gnt !== 2'b01) begin errs++; $display("FAIL fp_gnt[%0d]: got %b want 01", k, fp_gnt); end
      if (k > 0) begin
        vec++; if (rdata !== exp_rd[k]) begin errs++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, rdata, exp_rd[k]); end
      end
    end
    req = 2'b00;
    tick();
    vec++; if (rvalid !== 2'b10) begin errs++; $display("FAIL rr_rvalid_tail: got %b want 10", rvalid); end
    vec++; if (rdata !== 8'h3C) begin errs++; $display("FAIL rr_rdata_tail: got %h want 3c", rdata); end
    tick();
  endtask

  task automatic test_reset_mid;
    set_req(0, 1'b0, 9'd5, 8'd3, 8'h00);
    req = 2'b01;
    tick();
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL rm_gnt: got %b want 01", gnt); end
    req   = 2'b00;
    rst_n = 1'b0;
    #1;
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL rm_gnt_async: got %b want 00", gnt); end
    vec++; if (fb_col !== 9'd0 || fb_row !== 8'd0) begin errs++; $display("FAIL rm_addr_async: got %0d,%0d want 0,0", fb_col, fb_row); end
    tick();
    vec++; if (rvalid !== 2'b00) begin errs++; $display("FAIL rm_rvalid: got %b want 00", rvalid); end
    vec++; if (fb_we !== 1'b0) begin errs++; $display("FAIL rm_fb_we: got %b want 0", fb_we); end
    tick();
    vec++; if (rvalid !== 2'b00) begin errs++; $display("FAIL rm_rvalid2: got %b want 00", rvalid); end
    rst_n = 1'b1;
    set_req(1, 1'b0, 9'd335, 8'd255, 8'h00);
    req = 2'b11;
    tick();
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL rm_first_gnt: got %b want 01", gnt); end
    req = 2'b10;
    tick();
    vec++; if (gnt !== 2'b10) begin errs++; $display("FAIL rm_second_gnt: got %b want 10", gnt); end
    vec++; if (rvalid !== 2'b01 || rdata !== 8'hA7) begin errs++; $display("FAIL rm_rd0: got %b/%h want 01/a7", rvalid, rdata); end
    req = 2'b00;
    tick();
    vec++; if (rvalid !== 2'b10 || rdata !== 8'h3C) begin errs++; $display("FAIL rm_rd1: got %b/%h want 10/3c", rvalid, rdata); end
    tick();
  endtask

  task automatic test_same_addr;
    set_req(0, 1'b1, 9'd10, 8'd20, 8'h5A);
    set_req(1, 1'b0, 9'd10, 8'd20, 8'h00);
    req = 2'b11;
    tick();
    vec++; if (gnt !== 2'b01 || fb_we !== 1'b1) begin errs++; $display("FAIL sa_wr: got %b/%b want 01/1", gnt, fb_we); end
    req = 2'b10;
    tick();
    vec++; if (gnt !== 2'b10 || fb_we !== 1'b0) begin errs++; $display("FAIL sa_rd: got %b/%b want 10/0", gnt, fb_we); end
    vec++; if (rvalid !== 2'b00) begin errs++; $display("FAIL sa_no_rvalid: got %b want 00", rvalid); end
    req = 2'b00;
    tick();
    vec++; if (rvalid !== 2'b10) begin errs++; $display("FAIL sa_rvalid: got %b want 10", rvalid); end
    vec++; if (rdata !== 8'h5A) begin errs++; $display("FAIL sa_rdata: got %h want 5a", rdata); end
    tick();
  endtask

  task automatic test_back_to_back;
    set_req(0, 1'b0, 9'd5, 8'd3, 8'h00);
    req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL b2b_gnt[%0d]: got %b want 01", k, gnt); end
      if (k > 0) begin
        vec++; if (rvalid !== 2'b01 || rdata !== 8'hA7) begin errs++; $display("FAIL b2b_rd[%0d]: got %b/%h want 01/a7", k, rvalid, rdata); end
      end
    end
    req = 2'b00;
    tick();
    vec++; if (gnt !== 2'b00 || rvalid !== 2'b01) begin errs++; $display("FAIL b2b_tail: got %b/%b want 00/01", gnt, rvalid); end
    tick();
    vec++; if (rvalid !== 2'b00) begin errs++; $display("FAIL b2b_end: got %b want 00", rvalid); end
  endtask

`ifdef FB_ARB_BOUNDS_CHK_EN
  task automatic test_bounds;
    vec++; if (oob_err !== 1'b0) begin errs++; $display("FAIL oob_pre: got %b want 0", oob_err); end
    set_req(0, 1'b1, 9'd340, 8'd0, 8'h77);
    req = 2'b01;
    tick();
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL oob_wr_gnt: got %b want 01", gnt); end
    vec++; if (fb_we !== 1'b0) begin errs++; $display("FAIL oob_wr_we: got %b want 0", fb_we); end
    vec++; if (oob_err !== 1'b1) begin errs++; $display("FAIL oob_err_set: got %b want 1", oob_err); end
    set_req(1, 1'b0, 9'd336, 8'd255, 8'h00);
    req = 2'b10;
    tick();
    vec++; if (gnt !== 2'b10) begin errs++; $display("FAIL oob_rd_gnt: got %b want 10", gnt); end
    req = 2'b00;
    tick();
    vec++; if (rvalid !== 2'b10 || rdata !== 8'h00) begin errs++; $display("FAIL oob_rd: got %b/%h want 10/00", rvalid, rdata); end
    vec++; if (oob_err !== 1'b1) begin errs++; $display("FAIL oob_err_sticky: got %b want 1", oob_err); end
    tick();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req       = 2'b00;
    req_we    = 2'b00;
    req_col   = 18'd0;
    req_row   = 16'd0;
    req_wdata = 16'd0;
    pl_en     = 1'b0;
    pl_addr   = 0;
    pl_data   = 8'h00;
    test_reset();
    test_single_read();
    test_write_read();
    test_rr_contention();
    test_reset_mid();
    test_same_addr();
    test_back_to_back();
`ifdef FB_ARB_BOUNDS_CHK_EN
    test_bounds();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
